// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
//
// Trap sequencer for SYSCALL, external interrupts and ERET. On acceptance it
// flushes the pipeline, writes EPC / Cause / Status into CP0 over successive
// cycles, then redirects the PC. The pipeline is stalled for the whole
// sequence. ERET flushes, clears Status.EXL, then returns to EPC.
//
// Parameters:
//   HANDLER_VEC  word-aligned trap handler entry address
//   IRQ_W        number of external interrupt lines (<= 6)
//
// Optional feature macro:
//   TRAP_IRQ_SYNC_EN  when defined, irq_in passes through a two-flop
//                     synchronizer before masking (+2 cycles IRQ latency).
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   irq_in          level-sensitive interrupt requests
//   syscall_req     SYSCALL in EX this cycle
//   eret_req        ERET in EX this cycle
//   ex_valid        EX holds a valid instruction (gates interrupts)
//   ex_pc           PC[31:2] of the EX instruction
//   status_in       current CP0 Status (IE bit0, EXL bit1, IM bits 15:10)
//   epc_in          current CP0 EPC
//   cp0_we/waddr/wdata  CP0 register-file write port
//   flush           kill IF/ID/EX
//   stall           freeze PC and pipeline registers
//   redirect_valid  load redirect_pc into PC
//   redirect_pc     new PC[31:2]
// ---------------------------------------------------------------------------
module trap_ctrl #(
    parameter logic [31:0] HANDLER_VEC = 32'h0000_1000,
    parameter int          IRQ_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IRQ_W-1:0] irq_in,
    input  logic             syscall_req,
    input  logic             eret_req,
    input  logic             ex_valid,
    input  logic [29:0]      ex_pc,
    input  logic [31:0]      status_in,
    input  logic [31:0]      epc_in,
    output logic             cp0_we,
    output logic [4:0]       cp0_waddr,
    output logic [31:0]      cp0_wdata,
    output logic             flush,
    output logic             stall,
    output logic             redirect_valid,
    output logic [29:0]      redirect_pc
);

    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] CODE_SYSCALL = 5'd8;
    localparam logic [4:0] CODE_INT     = 5'd0;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FLUSH,
        S_W_EPC,
        S_W_CAUSE,
        S_W_STAT,
        S_REDIR,
        S_E_FLUSH,
        S_E_STAT,
        S_E_REDIR
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [29:0] epc_r;
    logic [4:0]  code_r;
    logic [5:0]  ip_r;

    logic [IRQ_W-1:0] irq_v;
    logic [5:0]       irq_ext;
    logic             irq_take;
    logic             trap_accept;

    // EPC low bits are always zero for a word-aligned return address.
    logic unused_epc_lsb;
    assign unused_epc_lsb = ^epc_in[1:0];

`ifdef TRAP_IRQ_SYNC_EN
    logic [IRQ_W-1:0] irq_s1;
    logic [IRQ_W-1:0] irq_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= irq_in;
            irq_s2 <= irq_s1;
        end
    end

    assign irq_v = irq_s2;
`else
    assign irq_v = irq_in;
`endif

    // Zero-extend the raw vector to the 6-bit Cause.IP field.
    always_comb begin
        irq_ext            = '0;
        irq_ext[IRQ_W-1:0] = irq_v;
    end

    assign irq_take = ex_valid && status_in[0] && !status_in[1]
                      && (|(irq_v & status_in[10 +: IRQ_W]));

    // A trap is accepted in IDLE when syscall wins, or when an interrupt is
    // pending and neither syscall nor eret outranks it.
    assign trap_accept = (state == S_IDLE)
                         && (syscall_req || (!eret_req && irq_take));

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (syscall_req)   state_nxt = S_FLUSH;
                else if (eret_req) state_nxt = S_E_FLUSH;
                else if (irq_take) state_nxt = S_FLUSH;
            end
            S_FLUSH:   state_nxt = S_W_EPC;
            S_W_EPC:   state_nxt = S_W_CAUSE;
            S_W_CAUSE: state_nxt = S_W_STAT;
            S_W_STAT:  state_nxt = S_REDIR;
            S_REDIR:   state_nxt = S_IDLE;
            S_E_FLUSH: state_nxt = S_E_STAT;
            S_E_STAT:  state_nxt = S_E_REDIR;
            S_E_REDIR: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // ---------------- trap context capture ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epc_r  <= '0;
            code_r <= '0;
            ip_r   <= '0;
        end else if (trap_accept) begin
            epc_r  <= ex_pc;
            code_r <= syscall_req ? CODE_SYSCALL : CODE_INT;
            ip_r   <= irq_ext;
        end
    end

    // ---------------- Moore outputs ----------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        cp0_we         = 1'b0;
        cp0_waddr      = '0;
        cp0_wdata      = '0;
        flush          = 1'b0;
        stall          = (state != S_IDLE);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state)
            S_FLUSH, S_E_FLUSH: flush = 1'b1;
            S_W_EPC: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_EPC;
                cp0_wdata = {epc_r, 2'b00};
            end
            S_W_CAUSE: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_CAUSE;
                cp0_wdata = {16'b0, ip_r, 3'b0, code_r, 2'b00};
            end
            S_W_STAT: begin
                // Enter exception level; Status is sampled live this cycle.
                cp0_we    = 1'b1;
                cp0_waddr = REG_STATUS;
                cp0_wdata = status_in | 32'h0000_0002;
            end
            S_E_STAT: begin
                cp0_we    = 1'b1;
                cp0_waddr = REG_STATUS;
                cp0_wdata = status_in & ~32'h0000_0002;
            end
            S_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = HANDLER_VEC[31:2];
            end
            S_E_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = epc_in[31:2];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
//
// Self-checking bench for trap_ctrl. A transaction-level reference model
// turns each accepted request into a queue of expected per-cycle output
// records; outputs are compared every cycle on the falling edge. Directed
// scenarios add literal checks on the captured CP0 writes and redirects,
// followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam logic [31:0] HANDLER = 32'h0000_1000;
`ifdef TRAP_IRQ_SYNC_EN
    localparam int IRQ_LAT = 2;
`else
    localparam int IRQ_LAT = 0;
`endif

    logic        clk;
    logic        rst;
    logic [5:0]  irq_in;
    logic        syscall_req;
    logic        eret_req;
    logic        ex_valid;
    logic [29:0] ex_pc;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [29:0] redirect_pc;

    trap_ctrl #(.HANDLER_VEC(HANDLER), .IRQ_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .irq_in         (irq_in),
        .syscall_req    (syscall_req),
        .eret_req       (eret_req),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .status_in      (status_in),
        .epc_in         (epc_in),
        .cp0_we         (cp0_we),
        .cp0_waddr      (cp0_waddr),
        .cp0_wdata      (cp0_wdata),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One expected cycle of a busy sequence. dsel: 0 fixed data,
    // 1 live status with EXL set, 2 live status with EXL cleared.
    // rsel: 0 fixed redirect, 1 live epc_in.
    typedef struct {
        bit          flush;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          dsel;
        bit          rv;
        logic [29:0] rpc;
        bit          rsel;
    } exp_t;

    exp_t        q[$];
    logic [5:0]  hist0, hist1;

    int n_tests = 0;
    int n_fail  = 0;

    // Captured activity during run().
    logic [31:0] cap_data [32];
    logic [31:0] cap_mask;
    logic [29:0] cap_rpc;
    int          cap_flush, cap_stall, cap_redir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(bit f, bit we, logic [4:0] a, logic [31:0] d, int ds,
                                bit rv, logic [29:0] rp, bit rs);
        exp_t e;
        e.flush = f; e.we = we; e.addr = a; e.data = d; e.dsel = ds;
        e.rv = rv; e.rpc = rp; e.rsel = rs;
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        hist0 = '0;
        hist1 = '0;
    endtask

    task automatic push_trap(input logic [4:0] code, input logic [5:0] ip, input logic [29:0] pc);
        logic [31:0] cause;
        cause = (32'(ip) << 10) | (32'(code) << 2);
        q.push_back(mk(1, 0, 0,  0,            0, 0, 0,                0));
        q.push_back(mk(0, 1, 14, 32'(pc) * 4,  0, 0, 0,                0));
        q.push_back(mk(0, 1, 13, cause,        0, 0, 0,                0));
        q.push_back(mk(0, 1, 12, 0,            1, 0, 0,                0));
        q.push_back(mk(0, 0, 0,  0,            0, 1, 30'(HANDLER / 4), 0));
    endtask

    task automatic push_eret();
        q.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 12, 0, 2, 0, 0, 0));
        q.push_back(mk(0, 0, 0,  0, 0, 1, 0, 1));
    endtask

    // Advance the model by one rising edge using the inputs held at that edge.
    task automatic model_step();
        logic [5:0] irq_eff;
        bit         irq_ok;
        if (rst) begin
            model_reset();
            return;
        end
`ifdef TRAP_IRQ_SYNC_EN
        irq_eff = hist1;
        hist1   = hist0;
        hist0   = irq_in;
`else
        irq_eff = irq_in;
`endif
        irq_ok = ex_valid && status_in[0] && !status_in[1]
                 && ((irq_eff & status_in[15:10]) != 0);
        if (q.size() != 0)   q.delete(0);
        else if (syscall_req) push_trap(5'd8, irq_eff, ex_pc);
        else if (eret_req)    push_eret();
        else if (irq_ok)      push_trap(5'd0, irq_eff, ex_pc);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] d;
        logic [29:0] rp;
        if (q.size() == 0) e = mk(0, 0, 0, 0, 0, 0, 0, 0);
        else               e = q[0];
        d = e.data;
        if (e.dsel == 1) d = status_in | 32'h2;
        if (e.dsel == 2) d = status_in & ~32'h2;
        rp = e.rsel ? epc_in[31:2] : e.rpc;
        check("flush", 32'(flush), 32'(e.flush));
        check("stall", 32'(stall), 32'(q.size() != 0));
        check("cp0_we", 32'(cp0_we), 32'(e.we));
        check("cp0_waddr", 32'(cp0_waddr), 32'(e.addr));
        check("cp0_wdata", cp0_wdata, d);
        check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        check("redirect_pc", 32'(redirect_pc), 32'(rp));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clear_cap();
        for (int i = 0; i < 32; i++) cap_data[i] = '0;
        cap_mask  = '0;
        cap_rpc   = '0;
        cap_flush = 0;
        cap_stall = 0;
        cap_redir = 0;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cycle();
            if (cp0_we) begin
                cap_data[cp0_waddr] = cp0_wdata;
                cap_mask[cp0_waddr] = 1'b1;
            end
            if (redirect_valid) begin
                cap_rpc = redirect_pc;
                cap_redir++;
            end
            if (flush) cap_flush++;
            if (stall) cap_stall++;
        end
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; syscall_req = 0; eret_req = 0; ex_valid = 0;
        ex_pc = '0; status_in = '0; epc_in = '0;
        model_reset();
        clear_cap();
        run(2);
        rst = 1'b0;

        // Idle after reset: nothing moves for 10 cycles.
        clear_cap();
        run(10);
        check("idle_stall", 32'(cap_stall), 0);
        check("idle_writes", cap_mask, 0);

        // Syscall.
        syscall_req = 1; ex_pc = 30'h0000_0040; ex_valid = 1;
        clear_cap();
        run(1);
        syscall_req = 0;
        check("sys_flush_first", 32'(flush), 1);
        run(4);
        check("sys_epc", cap_data[14], 32'h0000_0100);
        check("sys_cause", cap_data[13], 32'h0000_0020);
        check("sys_status", cap_data[12], 32'h0000_0002);
        check("sys_rpc", 32'(cap_rpc), 32'h0000_0400);
        check("sys_stall_len", 32'(cap_stall), 5);
        run(1);
        check("sys_done", 32'(stall), 0);

        // Interrupt on line 0.
        status_in = 32'h0000_0401; irq_in = 6'b000001; ex_pc = 30'h123;
        clear_cap();
        run(1 + IRQ_LAT);
        irq_in = '0;
        run(5);
        check("irq_cause", cap_data[13], 32'h0000_0400);
        check("irq_epc", cap_data[14], 32'h0000_048C);
        check("irq_status", cap_data[12], 32'h0000_0403);
        check("irq_rpc", 32'(cap_rpc), 32'h0000_0400);
        check("irq_regs", cap_mask, 32'h0000_7000);

        // EXL=1 blocks the interrupt.
        status_in = 32'h0000_0403; irq_in = 6'b000001;
        clear_cap();
        run(8);
        check("exl_writes", cap_mask, 0);
        check("exl_stall", 32'(cap_stall), 0);

        // IM0=0 masks it.
        status_in = 32'h0000_0001;
        clear_cap();
        run(8);
        check("im_writes", cap_mask, 0);
        check("im_stall", 32'(cap_stall), 0);
        irq_in = '0; status_in = '0;
        run(1 + IRQ_LAT);

        // ERET.
        status_in = 32'h0000_0003; epc_in = 32'h0000_0100; eret_req = 1;
        clear_cap();
        run(1);
        eret_req = 0;
        run(3);
        check("eret_flush", 32'(cap_flush), 1);
        check("eret_status", cap_data[12], 32'h0000_0001);
        check("eret_regs", cap_mask, 32'h0000_1000);
        check("eret_rpc", 32'(cap_rpc), 32'h0000_0040);
        check("eret_redir", 32'(cap_redir), 1);

        // Syscall and interrupt together: syscall wins, interrupt follows.
        status_in = '0; irq_in = 6'b000001; ex_valid = 1;
        run(IRQ_LAT);
        status_in = 32'h0000_0401; syscall_req = 1; ex_pc = 30'h40;
        clear_cap();
        run(1);
        syscall_req = 0;
        run(4);
        check("both_cause", cap_data[13], 32'h0000_0420);
        clear_cap();
        run(7);
        check("both_irq_cause", cap_data[13], 32'h0000_0400);
        check("both_irq_redir", 32'(cap_redir), 1);
        status_in = '0; irq_in = '0;
        run(1 + IRQ_LAT);

        // Reset during W_CAUSE.
        syscall_req = 1; ex_pc = 30'h55;
        run(1);
        syscall_req = 0;
        run(2);
        check("pre_rst_waddr", 32'(cp0_waddr), 13);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        clear_cap();
        run(1);
        rst = 1'b0;
        run(6);
        check("post_rst_writes", cap_mask, 0);
        check("post_rst_stall", 32'(cap_stall), 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(99) == 0);
            syscall_req = ($urandom_range(7) == 0);
            eret_req    = ($urandom_range(7) == 0);
            ex_valid    = $urandom_range(1);
            irq_in      = ($urandom_range(3) == 0) ? 6'($urandom) : 6'd0;
            status_in   = $urandom;
            epc_in      = $urandom;
            ex_pc       = 30'($urandom);
            run(1);
        end
        rst = 1'b0;
        syscall_req = 0; eret_req = 0; irq_in = '0;
        run(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
